btb_update_ctrl: RTL

Write-side controller for the 128-entry direct-mapped BTB. Accepts up to two retired-branch updates per cycle from the commit stage and buffers them in a small FIFO. It drains one update per cycle into the BTB's single write port. It also sequences a full-table invalidation sweep on reset and on flush request, and stalls retirement while the sweep runs.

---
 rtl/btb_update_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/btb_update_ctrl.sv
// -----------------------------------------------------------------------------
// btb_update_ctrl
//
// Write-side controller for the direct-mapped BTB. Each cycle the commit stage
// may retire up to two taken branches; the updates are buffered in a small
// FIFO and drained one per cycle into the BTB's single write port. A full
// invalidation sweep runs after reset and after every flush request. While
// the sweep runs, retirement is stalled.
//
// Handshake: the commit stage may assert retire0_vld/retire1_vld only in a
// cycle where retire_ready is high. An update is taken at the rising edge that
// ends that cycle. btb_wr_en is a one-way strobe and is suppressed whenever
// btb_wr_block is high. The FIFO head moves only on a cycle where btb_wr_en
// is high.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   retire0_* / retire1_* older / younger retiring taken branch (vld, pc, target)
//   retire_ready          room for two updates and not sweeping
//   flush_req             one-cycle pulse: discard queue, restart sweep
//   flush_busy            invalidation sweep in progress
//   btb_wr_block          BTB write port unavailable this cycle
//   btb_wr_en/pc/target   head-of-queue write into the BTB
//   btb_inv_en/idx        invalidate one BTB entry per cycle during sweep
// -----------------------------------------------------------------------------
module btb_update_ctrl #(
  parameter int QUEUE_DEPTH = 4,
  parameter int INDEX_W     = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               retire0_vld,
  input  logic [31:0]        retire0_pc,
  input  logic [31:0]        retire0_target,
  input  logic               retire1_vld,
  input  logic [31:0]        retire1_pc,
  input  logic [31:0]        retire1_target,
  output logic               retire_ready,
  input  logic               flush_req,
  output logic               flush_busy,
  input  logic               btb_wr_block,
  output logic               btb_wr_en,
  output logic [31:0]        btb_wr_pc,
  output logic [31:0]        btb_wr_target,
  output logic               btb_inv_en,
  output logic [INDEX_W-1:0] btb_inv_idx
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [INDEX_W-1:0] SWEEP_LAST = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t             state;
  logic [INDEX_W-1:0] sweep_cnt;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   wr_ptr_p1;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   free_slots;
  logic [CNT_W-1:0]   count_next;

  logic [31:0] pc_mem  [QUEUE_DEPTH];
  logic [31:0] tgt_mem [QUEUE_DEPTH];

  // Two write ports into the FIFO storage: port a at wr_ptr, port b at wr_ptr+1.
  logic        wa_en;
  logic [31:0] wa_pc;
  logic [31:0] wa_tgt;
  logic        wb_en;
  logic [31:0] wb_pc;
  logic [31:0] wb_tgt;
  logic [1:0]  push_cnt;
  logic        same_idx;
  logic        enq_ok;
  logic        pop;

  // ---------------------------------------------------------------------------
  // Status / handshake outputs (combinational from state and occupancy)
  // ---------------------------------------------------------------------------
  assign free_slots   = CNT_W'(QUEUE_DEPTH) - count;
  assign retire_ready = (state == RUN) && (free_slots >= CNT_W'(2));
  assign flush_busy   = (state == CLEAR);
  assign btb_inv_en   = (state == CLEAR);
  assign btb_inv_idx  = sweep_cnt;

  assign btb_wr_en     = (state == RUN) && (count != '0) && !btb_wr_block;
  assign btb_wr_pc     = (count != '0) ? pc_mem[rd_ptr]  : 32'h0;
  assign btb_wr_target = (count != '0) ? tgt_mem[rd_ptr] : 32'h0;
  assign pop           = btb_wr_en;

  // ---------------------------------------------------------------------------
  // Enqueue selection. Two updates that map to the same BTB entry collapse to
  // the younger one, since it would overwrite the older one anyway.
  // ---------------------------------------------------------------------------
  assign same_idx  = (retire0_pc[INDEX_W+3:4] == retire1_pc[INDEX_W+3:4]);
  assign enq_ok    = retire_ready && !flush_req;
  assign wr_ptr_p1 = wr_ptr + PTR_W'(1);

  always_comb begin
    wa_en    = 1'b0;
    wa_pc    = retire0_pc;
    wa_tgt   = retire0_target;
    wb_en    = 1'b0;
    wb_pc    = retire1_pc;
    wb_tgt   = retire1_target;
    push_cnt = 2'd0;
    if (enq_ok) begin
      if (retire0_vld && retire1_vld && !same_idx) begin
        wa_en    = 1'b1;
        wb_en    = 1'b1;
        push_cnt = 2'd2;
      end else if (retire1_vld) begin
        // Younger-only, or both valid aliasing one entry: slot1 goes first.
        wa_en    = 1'b1;
        wa_pc    = retire1_pc;
        wa_tgt   = retire1_target;
        push_cnt = 2'd1;
      end else if (retire0_vld) begin
        wa_en    = 1'b1;
        push_cnt = 2'd1;
      end
    end
  end

  assign count_next = count + CNT_W'(push_cnt) - CNT_W'(pop);

  // FIFO storage needs no reset; the count gates every read of it.
  always_ff @(posedge clk) begin
    if (wa_en) begin
      pc_mem[wr_ptr]  <= wa_pc;
      tgt_mem[wr_ptr] <= wa_tgt;
    end
    if (wb_en) begin
      pc_mem[wr_ptr_p1]  <= wb_pc;
      tgt_mem[wr_ptr_p1] <= wb_tgt;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM, sweep counter and FIFO pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (flush_req) begin
            sweep_cnt <= '0;
          end else if (sweep_cnt == SWEEP_LAST) begin
            state     <= RUN;
            sweep_cnt <= '0;
          end else begin
            sweep_cnt <= sweep_cnt + INDEX_W'(1);
          end
        end
        RUN: begin
          if (flush_req) begin
            // Pending updates are stale after a flush; drop the whole queue.
            state     <= CLEAR;
            sweep_cnt <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
          end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count_next;
          end
        end
        default: begin
          state     <= CLEAR;
          sweep_cnt <= '0;
        end
      endcase
    end
  end

endmodule
